// File: rtl/instr_fetch_mem_if.sv
// Fetch-side bus for instr_fetch_mem: request (PC -> memory) and
// response (memory -> decode) valid/ready channels.
// master = fetch stage, slave = instruction memory.
`timescale 1ns/1ps
interface instr_fetch_mem_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;

   modport master (
      output req_valid, req_addr, rsp_ready,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_addr, rsp_ready,
      output req_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/instr_fetch_mem.sv
// Multi-cycle instruction memory with a valid/ready fetch port, a
// configurable read latency and a never-blocked program-load write port.
// Optional feature macro: IMEM_HALT_EN (fetches at or beyond prog_len
// return NOP_WORD and raise a sticky halt flag).
`timescale 1ns/1ps
module instr_fetch_mem #(
   parameter int                DATA_W   = 32,
   parameter int                ADDR_W   = 5,
   parameter int                LATENCY  = 3,
   parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
   input  logic                clk,
   input  logic                rst_n,
   instr_fetch_mem_if.slave    bus,
   input  logic                ld_en,
   input  logic [ADDR_W-1:0]   ld_addr,
   input  logic [DATA_W-1:0]   ld_data,
   input  logic [ADDR_W:0]     prog_len,
   output logic                halt
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];

   logic [1:0]        r_state;
   logic [3:0]        r_cnt;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_rsp_data;
   logic              r_halt;

   logic              w_req_ready;
   logic              w_accept;
   logic              w_rd_en;
   logic [ADDR_W-1:0] w_rd_addr;
   logic [DATA_W-1:0] w_rd_word;
   logic              w_hit_end;
   logic [DATA_W-1:0] w_rsp_next;

   assign w_req_ready = (r_state == S_IDLE) && !r_halt;
   assign w_accept    = bus.req_valid && w_req_ready;

   // With LATENCY=1 the array is read on the acceptance edge itself,
   // so the live request address is used instead of the latched one.
   assign w_rd_addr = (LATENCY == 1) ? bus.req_addr : r_addr;
   assign w_rd_word = r_mem[w_rd_addr];

   // Read strobe: the array is sampled on the edge that brings the wait
   // counter to zero, which puts RESP LATENCY-1 edges after acceptance
   // and gives one fetch per LATENCY+1 cycles with rsp_ready held high.
   always_comb begin
      w_rd_en = 1'b0;
      if (LATENCY == 1) begin
         w_rd_en = (r_state == S_IDLE) && w_accept;
      end else begin
         w_rd_en = (r_state == S_WAIT) && (r_cnt == 4'd1);
      end
   end

`ifdef IMEM_HALT_EN
   assign w_hit_end  = ({1'b0, w_rd_addr} >= prog_len);
   assign w_rsp_next = w_hit_end ? NOP_WORD : w_rd_word;
`else
   logic w_unused_cfg;
   assign w_unused_cfg = ^{prog_len, NOP_WORD};
   assign w_hit_end    = 1'b0;
   assign w_rsp_next   = w_rd_word;
`endif

   assign bus.req_ready = w_req_ready;
   assign bus.rsp_valid = (r_state == S_RESP);
   assign bus.rsp_data  = r_rsp_data;
   assign halt          = r_halt;

   // Program-load write; nonblocking so a same-edge read sees old data.
   always_ff @(posedge clk) begin
      if (ld_en) begin
         r_mem[ld_addr] <= ld_data;
      end
   end

   // Fetch FSM: accept, count down the latency, hold the response.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_addr     <= '0;
         r_rsp_data <= '0;
         r_halt     <= 1'b0;
      end else begin
         if (w_rd_en) begin
            r_rsp_data <= w_rsp_next;
            if (w_hit_end) begin
               r_halt <= 1'b1;
            end
         end
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_addr  <= bus.req_addr;
                  r_cnt   <= CNT_INIT;
                  r_state <= (LATENCY == 1) ? S_RESP : S_WAIT;
               end
            end
            S_WAIT: begin
               r_cnt <= r_cnt - 4'd1;
               if (w_rd_en) begin
                  r_state <= S_RESP;
               end
            end
            S_RESP: begin
               if (bus.rsp_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Self-checking bench for instr_fetch_mem: a LATENCY=3 instance checked
// through a response scoreboard and a LATENCY=1 instance checked inline.
`timescale 1ns/1ps
module tb_instr_fetch_mem;

   localparam int LAT3 = 3;

   typedef struct {
      logic [31:0] d;
      logic        h;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ld_en = 1'b0;
   logic [4:0]  ld_addr = '0;
   logic [31:0] ld_data = '0;
   logic [5:0]  prog_len = 6'd5;
   logic        halt3;
   logic        halt1;

   instr_fetch_mem_if #(.ADDR_W(5), .DATA_W(32)) b3 ();
   instr_fetch_mem_if #(.ADDR_W(5), .DATA_W(32)) b1 ();

   instr_fetch_mem #(.DATA_W(32), .ADDR_W(5), .LATENCY(LAT3), .NOP_WORD(32'h0000_0000)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .bus(b3), .ld_en(ld_en), .ld_addr(ld_addr),
      .ld_data(ld_data), .prog_len(prog_len), .halt(halt3)
   );

   instr_fetch_mem #(.DATA_W(32), .ADDR_W(5), .LATENCY(1), .NOP_WORD(32'h0000_0000)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .bus(b1), .ld_en(ld_en), .ld_addr(ld_addr),
      .ld_data(ld_data), .prog_len(prog_len), .halt(halt1)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference program image
   logic [31:0] m_mem [0:31];
   exp_t        q3 [$];
   logic        m_halt   = 1'b0;
   logic        stream   = 1'b0;
   int          cyc      = 0;
   int          acc_cyc  = 0;
   logic        have_acc = 1'b0;
   logic        prev_v3  = 1'b0;
   logic [31:0] prev_d3  = '0;
   logic        post_hs  = 1'b0;

   // Monitor for the LATENCY=3 instance, sampled on the falling edge
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (!rst_n) begin
         q3.delete();
         prev_v3  = 1'b0;
         have_acc = 1'b0;
         post_hs  = 1'b0;
         m_halt   = 1'b0;
      end else begin
         if (post_hs) begin
            chk("idle_ready", 32'(b3.req_ready), 32'(!m_halt));
            chk("idle_valid", 32'(b3.rsp_valid), 32'd0);
            post_hs = 1'b0;
         end
         if (b3.rsp_valid) begin
            chk("busy_ready", 32'(b3.req_ready), 32'd0);
            if (!prev_v3) begin
               chk("rsp_pending", 32'(q3.size() != 0), 32'd1);
               chk("rsp_latency", 32'(cyc - acc_cyc), 32'(LAT3));
               if (q3.size() != 0) chk("rsp_halt", 32'(halt3), 32'(q3[0].h));
            end else begin
               chk("rsp_stable", b3.rsp_data, prev_d3);
            end
            if (b3.rsp_ready && q3.size() != 0) begin
               e = q3.pop_front();
               chk("rsp_data", b3.rsp_data, e.d);
               m_halt  = m_halt | e.h;
               post_hs = 1'b1;
            end
         end
         if (b3.req_valid && b3.req_ready) begin
`ifdef IMEM_HALT_EN
            e.h = ({1'b0, b3.req_addr} >= prog_len);
`else
            e.h = 1'b0;
`endif
            e.d = e.h ? 32'h0000_0000 : m_mem[b3.req_addr];
            q3.push_back(e);
            if (stream && have_acc) chk("throughput", 32'(cyc - acc_cyc), 32'(LAT3 + 1));
            acc_cyc  = cyc;
            have_acc = stream;
         end
         prev_v3 = b3.rsp_valid;
         prev_d3 = b3.rsp_data;
      end
   end

   task automatic load(input logic [4:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      @(posedge clk);
      m_mem[a] = d;
      #1 ld_en = 1'b0;
   endtask

   task automatic wait_ready3();
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (b3.req_ready) break;
      end
      chk("req_timeout", 32'(b3.req_ready), 32'd1);
   endtask

   task automatic wait_rsp3(input int hold);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (b3.rsp_valid) break;
      end
      chk("rsp_timeout", 32'(b3.rsp_valid), 32'd1);
      repeat (hold) @(posedge clk);
      @(posedge clk); #1 b3.rsp_ready = 1'b1;
      @(posedge clk); #1 b3.rsp_ready = 1'b0;
   endtask

   task automatic do_fetch3(input logic [4:0] a, input int hold);
      @(posedge clk); #1;
      b3.req_valid = 1'b1; b3.req_addr = a;
      wait_ready3();
      @(posedge clk); #1 b3.req_valid = 1'b0;
      wait_rsp3(hold);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
      $fatal(1);
   end

   initial begin
      int n;
      logic [31:0] prog [0:4];
      prog[0] = 32'h2001_0003; prog[1] = 32'h2002_0003; prog[2] = 32'h0022_1818;
      prog[3] = 32'h8C41_000A; prog[4] = 32'h1022_0014;
      b3.req_valid = 1'b0; b3.req_addr = '0; b3.rsp_ready = 1'b0;
      b1.req_valid = 1'b0; b1.req_addr = '0; b1.rsp_ready = 1'b0;

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_req_ready", 32'(b3.req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(b3.rsp_valid), 32'd0);
      chk("rst_rsp_data",  b3.rsp_data, 32'd0);
      chk("rst_halt",      32'(halt3), 32'd0);
      chk("rst_l1_ready",  32'(b1.req_ready), 32'd1);

      for (int i = 0; i < 5; i++) load(5'(i), prog[i]);
      load(5'd5, 32'h0000_0555);

      // Streaming fetch of words 0..4 with rsp_ready held high
      @(posedge clk); #1;
      stream = 1'b1; b3.rsp_ready = 1'b1; b3.req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         b3.req_addr = 5'(i);
         wait_ready3();
         @(posedge clk); #1;
      end
      b3.req_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (q3.size() == 0 && !b3.rsp_valid) break;
      end
      chk("stream_drain", 32'(q3.size()), 32'd0);
      @(posedge clk); #1;
      stream = 1'b0; b3.rsp_ready = 1'b0;

      // Back-pressure on address 2
      do_fetch3(5'd2, 7);

      // Read/write collision on address 3
      @(posedge clk); #1;
      b3.req_valid = 1'b1; b3.req_addr = 5'd3;
      wait_ready3();
      @(posedge clk); #1 b3.req_valid = 1'b0;
      @(posedge clk); #1;
      ld_en = 1'b1; ld_addr = 5'd3; ld_data = 32'hDEAD_BEEF;
      @(posedge clk);
      m_mem[3] = 32'hDEAD_BEEF;
      #1 ld_en = 1'b0;
      wait_rsp3(0);
      do_fetch3(5'd3, 0);

      // LATENCY=1 instance
      @(posedge clk); #1;
      b1.req_valid = 1'b1; b1.req_addr = 5'd0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (b1.req_ready) break;
      end
      chk("l1_req_ready", 32'(b1.req_ready), 32'd1);
      @(posedge clk); #1 b1.req_valid = 1'b0;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         n++;
         if (b1.rsp_valid) break;
      end
      chk("l1_latency", 32'(n), 32'd1);
      chk("l1_data", b1.rsp_data, m_mem[0]);
      @(posedge clk); #1 b1.rsp_ready = 1'b1;
      @(posedge clk); #1 b1.rsp_ready = 1'b0;
      @(negedge clk);
      chk("l1_idle", 32'(b1.req_ready), 32'd1);

      // Reset while the fetch of address 1 is waiting
      @(posedge clk); #1;
      b3.req_valid = 1'b1; b3.req_addr = 5'd1;
      wait_ready3();
      @(posedge clk); #1;
      b3.req_valid = 1'b0; rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("mid_rst_valid", 32'(b3.rsp_valid), 32'd0);
      chk("mid_rst_data",  b3.rsp_data, 32'd0);
      chk("mid_rst_ready", 32'(b3.req_ready), 32'd1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("no_stale_rsp", 32'(b3.rsp_valid), 32'd0);
      end

      // End-of-program fetches
      do_fetch3(5'd4, 0);
      @(negedge clk);
      chk("halt_before_end", 32'(halt3), 32'd0);
      do_fetch3(5'd5, 0);
`ifdef IMEM_HALT_EN
      @(posedge clk); #1;
      b3.req_valid = 1'b1; b3.req_addr = 5'd0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("halt_blocks_req", 32'(b3.req_ready), 32'd0);
      end
      @(posedge clk); #1 b3.req_valid = 1'b0;
      @(negedge clk);
      chk("halt_sticky", 32'(halt3), 32'd1);
`else
      @(negedge clk);
      chk("halt_tied_low", 32'(halt3), 32'd0);
`endif

      // Reset clears halt and returns to IDLE
      @(posedge clk); #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("final_halt",  32'(halt3), 32'd0);
      chk("final_ready", 32'(b3.req_ready), 32'd1);
      chk("sb_empty",    32'(q3.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_fetch_mem.md
# instr_fetch_mem

Parametrised, multi-cycle instruction memory that replaces the fixed-pace fetch ROM used by the single-cycle core. It serves word-indexed fetch requests over a valid/ready handshake with configurable read latency and response back-pressure. A program-load write port lets the testbench or boot logic fill memory at run time. It sits between the PC/fetch stage and the decode stage of the MIPS datapath.

## Interface
- `DATA_W`, 32: instruction word width in bits.
- `ADDR_W`, 5: word-address width; depth is 2**ADDR_W words.
- `LATENCY`, 3: cycles from request acceptance to response valid; legal range 1..15.
- `NOP_WORD`, 32'h0000_0000: word returned in place of memory data on a halting fetch.

- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `req_valid`  in  1  fetch request present.
- `req_ready`  out  1  block can accept a request.
- `req_addr`  in  ADDR_W  word address of the fetch.
- `rsp_valid`  out  1  `rsp_data` holds a fetched instruction.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_data`  out  DATA_W  fetched instruction.
- `ld_en`  in  1  program-load write strobe.
- `ld_addr`  in  ADDR_W  program-load word address.
- `ld_data`  in  DATA_W  program-load word.
- `prog_len`  in  ADDR_W+1  number of valid program words; used only with `IMEM_HALT_EN`.
- `halt`  out  1  sticky end-of-program flag; used only with `IMEM_HALT_EN`.

## Operation
- Storage is a 2**ADDR_W x DATA_W array. It is not cleared by reset and holds X until it is written.
- FSM states:
  - IDLE: `req_ready`=1. `req_valid`=1 latches `req_addr`, loads the wait counter with LATENCY-1, and moves to WAIT. If LATENCY=1, the block moves directly to RESP.
  - WAIT: counter decrements each cycle. On the cycle the counter is 0, the array is read at the latched address into `rsp_data` and the FSM moves to RESP.
  - RESP: `rsp_valid`=1 and `rsp_data` is held stable. `rsp_ready`=1 returns the FSM to IDLE.
- Only one request is in flight at a time. `req_ready` is 0 outside IDLE. The cycle after a response handshake is always IDLE, so there is no back-to-back acceptance in the response cycle.
- Load port:
  - `ld_en` writes `ld_data` to `ld_addr` on the edge, in any state, and is never blocked.
  - When the array read and a write to the same address occur on the same edge, the read returns the old data (read-before-write).
- Reset mid-operation drops any in-flight request; no response is produced for it.

## Timing
- Request accepted at edge t (`req_valid` & `req_ready`) gives `rsp_valid`=1 from cycle t+LATENCY.
- Fetch throughput with `rsp_ready` tied high is one instruction per LATENCY+1 cycles.
- `rsp_valid` stays high and `rsp_data` stays constant until `rsp_ready` is sampled high; back-pressure of any length is legal.
- Reset values:
  - State IDLE, so `req_ready`=1 on the first cycle after reset.
  - `rsp_valid`=0, `rsp_data`=0, `halt`=0, wait counter 0, latched address 0.

## Configuration
- `IMEM_HALT_EN` defined:
  - An accepted request with `req_addr` >= `prog_len` still takes LATENCY cycles, returns `NOP_WORD`, and sets `halt`=1 on the same edge that raises `rsp_valid`.
  - `halt` stays 1 until reset.
  - While `halt`=1, `req_ready` is 0 in IDLE, so no further requests are accepted.
  - `prog_len`=0 makes every fetch halt.
- `IMEM_HALT_EN` undefined:
  - `prog_len` is ignored, `halt` is tied to 0, and every address returns array contents.

## Test plan
- Load and read: load words 0..4 = 32'h2001_0003, 32'h2002_0003, 32'h0022_1818, 32'h8C41_000A, 32'h1022_0014 with LATENCY=3, then fetch addresses 0..4 with `rsp_ready`=1. Expect each word exactly 3 cycles after acceptance, with 4 cycles between acceptances.
- Back-pressure: fetch address 2 and hold `rsp_ready`=0 for 7 cycles. Expect `rsp_valid`=1 and `rsp_data`=32'h0022_1818 stable throughout, `req_ready`=0, and IDLE the cycle after `rsp_ready`=1.
- Read/write collision: fetch address 3 while `ld_en` writes 32'hDEAD_BEEF to address 3 on the read edge. Expect the response to be 32'h8C41_000A, and the next fetch of address 3 to return 32'hDEAD_BEEF.
- Mid-fetch reset: deassert `rst_n` during WAIT. Expect `rsp_valid`=0, `rsp_data`=0, `req_ready`=1 after release, and no stale response.
- Halt (`IMEM_HALT_EN`, `prog_len`=5): fetch address 4 returns 32'h1022_0014 with `halt`=0. Fetch address 5 returns 32'h0000_0000 with `halt`=1, and `req_ready` stays 0 afterwards.
- Latency edge: LATENCY=1, fetch address 0. Expect `rsp_valid` on the cycle after acceptance.
